// File: rtl/pll_sup_pkg.sv
// Shared types and sizing helpers for the PLL lock supervisor.
// State encoding and retry counter width live here for reuse.
package pll_sup_pkg;

    typedef enum logic [2:0] {
        ST_RESET_PLL,
        ST_WAIT_LOCK,
        ST_STABLE,
        ST_RELEASE,
        ST_RUN,
        ST_FAULT
    } sup_state_t;

    localparam int RETRY_W = 4;
    localparam logic [RETRY_W-1:0] RETRY_SAT = '1;

    function automatic int unsigned max4(
        input int unsigned a,
        input int unsigned b,
        input int unsigned c,
        input int unsigned d
    );
        int unsigned m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        if (d > m) m = d;
        return m;
    endfunction

    // Bits needed to hold the value v itself (not v-1).
    function automatic int unsigned cnt_width(input int unsigned v);
        return $clog2(v + 1);
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for a single asynchronous level.
// Both flops clear to 0 under reset.
module sync_2ff (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            meta <= 1'b0;
            q    <= 1'b0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/pll_lock_supervisor.sv
// Sequences PLL reset, waits for a stable lock, then releases
// downstream resets one channel at a time; retries or faults on loss.
module pll_lock_supervisor
    import pll_sup_pkg::*;
#(
    parameter int NUM_OUT          = 2,
    parameter int PLL_RST_CYCLES   = 16,
    parameter int LOCK_WAIT_CYCLES = 50000,
    parameter int STABLE_CYCLES    = 1024,
    parameter int STAGGER_CYCLES   = 8,
    parameter int MAX_RETRIES      = 3
) (
    input  logic               clkin,
    input  logic               reset,
    input  logic               pll_lock,
    input  logic               restart,
    output logic               pll_reset,
    output logic [NUM_OUT-1:0] rst_out,
    output logic               ready,
    output logic               fault,
    output logic [RETRY_W-1:0] retry_cnt
);

    localparam int CNT_MAX = int'(max4(PLL_RST_CYCLES, LOCK_WAIT_CYCLES,
                                       STABLE_CYCLES, STAGGER_CYCLES));
    localparam int CW = int'(cnt_width(CNT_MAX));

    localparam logic [CW-1:0] LD_RST    = CW'(PLL_RST_CYCLES);
    localparam logic [CW-1:0] LD_WAIT   = CW'(LOCK_WAIT_CYCLES);
    localparam logic [CW-1:0] LD_STABLE = CW'(STABLE_CYCLES);
    localparam logic [CW-1:0] LD_STAG   = CW'(STAGGER_CYCLES);
    localparam logic [CW-1:0] CNT_ONE   = CW'(1);

    localparam logic [NUM_OUT-1:0] ALL_RST   = '1;
    localparam logic [NUM_OUT-1:0] FIRST_REL = ALL_RST << 1;
    localparam logic [RETRY_W-1:0] MAX_R     = RETRY_W'(MAX_RETRIES);

    logic               lock_s;
    sup_state_t         state, state_nx;
    logic [CW-1:0]      cnt, cnt_nx;
    logic [NUM_OUT-1:0] rst_q, rst_nx;
    logic [RETRY_W-1:0] retry_q, retry_nx;
    logic               last;
    logic               fail;

    sync_2ff u_sync (
        .clk (clkin),
        .rst (reset),
        .d   (pll_lock),
        .q   (lock_s)
    );

    // rst_out is a register so reset can force it high asynchronously.
    always_ff @(posedge clkin or posedge reset) begin
        if (reset) begin
            state   <= ST_RESET_PLL;
            cnt     <= LD_RST;
            rst_q   <= ALL_RST;
            retry_q <= '0;
        end else begin
            state   <= state_nx;
            cnt     <= cnt_nx;
            rst_q   <= rst_nx;
            retry_q <= retry_nx;
        end
    end

    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        rst_nx   = rst_q;
        retry_nx = retry_q;
        fail     = 1'b0;
        last     = (cnt == CNT_ONE);

        unique case (state)
            ST_RESET_PLL: begin
                if (last) begin
                    state_nx = ST_WAIT_LOCK;
                    cnt_nx   = LD_WAIT;
                end else begin
                    cnt_nx = cnt - 1'b1;
                end
            end
            ST_WAIT_LOCK: begin
                if (lock_s) begin
                    state_nx = ST_STABLE;
                    cnt_nx   = LD_STABLE;
                end else if (last) begin
                    fail = 1'b1;
                end else begin
                    cnt_nx = cnt - 1'b1;
                end
            end
            ST_STABLE: begin
                if (!lock_s) begin
                    state_nx = ST_WAIT_LOCK;
                    cnt_nx   = LD_WAIT;
                end else if (last) begin
                    state_nx = ST_RELEASE;
                    cnt_nx   = LD_STAG;
                    rst_nx   = FIRST_REL;
                end else begin
                    cnt_nx = cnt - 1'b1;
                end
            end
            ST_RELEASE: begin
                if (!lock_s) begin
                    fail = 1'b1;
                end else if (last) begin
                    cnt_nx = LD_STAG;
                    // One extra stagger slot after the last channel.
                    if (rst_q == '0) begin
                        state_nx = ST_RUN;
                        retry_nx = '0;
                    end else begin
                        rst_nx = rst_q << 1;
                    end
                end else begin
                    cnt_nx = cnt - 1'b1;
                end
            end
            ST_RUN: begin
                if (!lock_s) fail = 1'b1;
            end
            ST_FAULT: begin
                state_nx = ST_FAULT;
            end
            default: begin
                state_nx = ST_RESET_PLL;
                cnt_nx   = LD_RST;
                rst_nx   = ALL_RST;
            end
        endcase

        if (fail) begin
            rst_nx = ALL_RST;
            if (retry_q < MAX_R) begin
                retry_nx = (retry_q == RETRY_SAT) ? retry_q
                                                  : retry_q + 1'b1;
                state_nx = ST_RESET_PLL;
                cnt_nx   = LD_RST;
            end else begin
                state_nx = ST_FAULT;
            end
        end

        if (restart) begin
            state_nx = ST_RESET_PLL;
            cnt_nx   = LD_RST;
            rst_nx   = ALL_RST;
            retry_nx = '0;
        end
    end

    assign pll_reset = (state == ST_RESET_PLL) || (state == ST_FAULT);
    assign rst_out   = rst_q;
    assign ready     = (state == ST_RUN);
    assign fault     = (state == ST_FAULT);
    assign retry_cnt = retry_q;

endmodule

// File: tb/tb_pll_lock_supervisor.sv
// Bench for pll_lock_supervisor: directed scenarios with literal
// expectations plus random lock/restart/reset traffic vs a timeline model.
module tb_pll_lock_supervisor;

    localparam int NO = 3;
    localparam int PR = 4;
    localparam int LW = 20;
    localparam int SC = 8;
    localparam int SG = 2;
    localparam int MR = 2;

    logic          clkin;
    logic          reset;
    logic          pll_lock;
    logic          restart;
    logic          pll_reset;
    logic [NO-1:0] rst_out;
    logic          ready;
    logic          fault;
    logic [3:0]    retry_cnt;

    int n_cmp = 0;
    int n_bad = 0;
    bit chk_en = 0;

    pll_lock_supervisor #(
        .NUM_OUT          (NO),
        .PLL_RST_CYCLES   (PR),
        .LOCK_WAIT_CYCLES (LW),
        .STABLE_CYCLES    (SC),
        .STAGGER_CYCLES   (SG),
        .MAX_RETRIES      (MR)
    ) dut (
        .clkin     (clkin),
        .reset     (reset),
        .pll_lock  (pll_lock),
        .restart   (restart),
        .pll_reset (pll_reset),
        .rst_out   (rst_out),
        .ready     (ready),
        .fault     (fault),
        .retry_cnt (retry_cnt)
    );

    initial clkin = 1'b0;
    always #5 clkin = ~clkin;

    // Timeline model: phase plus cycles elapsed inside it.
    localparam int M_PRST = 0;
    localparam int M_WAIT = 1;
    localparam int M_STAB = 2;
    localparam int M_REL  = 3;
    localparam int M_RUN  = 4;
    localparam int M_FLT  = 5;

    int       m_mode;
    int       m_el;
    int       m_retry;
    bit [1:0] m_hist;

    task automatic m_fail();
        if (m_retry < MR) begin
            m_retry = (m_retry >= 15) ? 15 : m_retry + 1;
            m_mode  = M_PRST;
            m_el    = 0;
        end else begin
            m_mode = M_FLT;
        end
    endtask

    always @(posedge clkin or posedge reset) begin
        if (reset) begin
            m_mode  = M_PRST;
            m_el    = 0;
            m_retry = 0;
            m_hist  = 2'b00;
        end else begin : step
            bit ls;
            ls     = m_hist[1];
            m_hist = {m_hist[0], pll_lock};
            if (restart) begin
                m_mode  = M_PRST;
                m_el    = 0;
                m_retry = 0;
            end else begin
                case (m_mode)
                    M_PRST: begin
                        m_el++;
                        if (m_el == PR) begin
                            m_mode = M_WAIT;
                            m_el   = 0;
                        end
                    end
                    M_WAIT: begin
                        if (ls) begin
                            m_mode = M_STAB;
                            m_el   = 0;
                        end else begin
                            m_el++;
                            if (m_el == LW) m_fail();
                        end
                    end
                    M_STAB: begin
                        if (!ls) begin
                            m_mode = M_WAIT;
                            m_el   = 0;
                        end else begin
                            m_el++;
                            if (m_el == SC) begin
                                m_mode = M_REL;
                                m_el   = 0;
                            end
                        end
                    end
                    M_REL: begin
                        if (!ls) m_fail();
                        else begin
                            m_el++;
                            if (m_el == NO * SG) begin
                                m_mode  = M_RUN;
                                m_retry = 0;
                            end
                        end
                    end
                    M_RUN: if (!ls) m_fail();
                    default: ;
                endcase
            end
        end
    end

    function automatic logic [NO-1:0] exp_rst();
        logic [NO-1:0] v;
        int rel;
        v = '1;
        if (m_mode == M_RUN) return '0;
        if (m_mode != M_REL) return v;
        rel = m_el / SG + 1;
        if (rel > NO) rel = NO;
        for (int i = 0; i < rel; i++) v[i] = 1'b0;
        return v;
    endfunction

    task automatic cmp(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t",
                     nm, act, exp, $time);
        end
    endtask

    always begin
        @(posedge clkin);
        #3;
        if (chk_en) begin
            cmp("m_rst_out", 32'(rst_out), 32'(exp_rst()));
            cmp("m_pll_reset", 32'(pll_reset),
                32'(m_mode == M_PRST || m_mode == M_FLT));
            cmp("m_ready", 32'(ready), 32'(m_mode == M_RUN));
            cmp("m_fault", 32'(fault), 32'(m_mode == M_FLT));
            cmp("m_retry_cnt", 32'(retry_cnt), 32'(m_retry));
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(negedge clkin);
    endtask

    task automatic wait_ready(input string nm, input int budget);
        int k;
        k = 0;
        while (ready !== 1'b1 && k < budget) begin
            @(negedge clkin);
            k++;
        end
        if (ready !== 1'b1) cmp(nm, 32'(ready), 32'd1);
    endtask

    task automatic pulse_reset(input logic lk);
        @(negedge clkin);
        reset    = 1'b1;
        restart  = 1'b0;
        pll_lock = lk;
        @(negedge clkin);
        reset = 1'b0;
    endtask

    initial begin : stim
        int seg;
        reset    = 1'b1;
        pll_lock = 1'b0;
        restart  = 1'b0;
        cyc(3);
        chk_en = 1'b1;
        cmp("rst_rst_out", 32'(rst_out), 32'b111);
        cmp("rst_pll_reset", 32'(pll_reset), 32'd1);
        cmp("rst_ready", 32'(ready), 32'd0);
        cmp("rst_fault", 32'(fault), 32'd0);
        cmp("rst_retry", 32'(retry_cnt), 32'd0);

        // Clean start with lock present from the first edge.
        pll_lock = 1'b1;
        reset    = 1'b0;
        cyc(3);
        cmp("cs_pll_reset_e3", 32'(pll_reset), 32'd1);
        cyc(1);
        cmp("cs_pll_reset_e4", 32'(pll_reset), 32'd0);
        cyc(8);
        cmp("cs_rst_e12", 32'(rst_out), 32'b111);
        cyc(1);
        cmp("cs_rst_e13", 32'(rst_out), 32'b110);
        cyc(2);
        cmp("cs_rst_e15", 32'(rst_out), 32'b100);
        cyc(2);
        cmp("cs_rst_e17", 32'(rst_out), 32'b000);
        cmp("cs_ready_e17", 32'(ready), 32'd0);
        cyc(2);
        cmp("cs_ready_e19", 32'(ready), 32'd1);
        cmp("cs_retry", 32'(retry_cnt), 32'd0);

        // Lock loss in RUN.
        pll_lock = 1'b0;
        cyc(2);
        cmp("ll_ready_hold", 32'(ready), 32'd1);
        cyc(1);
        cmp("ll_rst", 32'(rst_out), 32'b111);
        cmp("ll_ready", 32'(ready), 32'd0);
        cmp("ll_retry", 32'(retry_cnt), 32'd1);
        pll_lock = 1'b1;
        wait_ready("ll_relock_timeout", 100);
        cmp("ll_retry_clr", 32'(retry_cnt), 32'd0);

        // One-cycle glitch while in STABLE.
        pulse_reset(1'b1);
        cyc(7);
        pll_lock = 1'b0;
        cyc(1);
        pll_lock = 1'b1;
        cyc(5);
        cmp("gl_rst_e13", 32'(rst_out), 32'b111);
        cyc(5);
        cmp("gl_rst_e18", 32'(rst_out), 32'b111);
        cyc(1);
        cmp("gl_rst_e19", 32'(rst_out), 32'b110);
        cmp("gl_retry", 32'(retry_cnt), 32'd0);

        // No lock at all: two retries then FAULT.
        pulse_reset(1'b0);
        cyc(23);
        cmp("nl_retry_e23", 32'(retry_cnt), 32'd0);
        cyc(1);
        cmp("nl_retry_e24", 32'(retry_cnt), 32'd1);
        cyc(24);
        cmp("nl_retry_e48", 32'(retry_cnt), 32'd2);
        cyc(23);
        cmp("nl_fault_e71", 32'(fault), 32'd0);
        cyc(1);
        cmp("nl_fault_e72", 32'(fault), 32'd1);
        cmp("nl_pll_reset", 32'(pll_reset), 32'd1);
        cmp("nl_retry_e72", 32'(retry_cnt), 32'd2);
        cyc(10);
        cmp("nl_fault_hold", 32'(fault), 32'd1);

        // Restart out of FAULT.
        restart  = 1'b1;
        pll_lock = 1'b1;
        cyc(1);
        restart = 1'b0;
        cmp("rs_fault", 32'(fault), 32'd0);
        cmp("rs_retry", 32'(retry_cnt), 32'd0);
        cyc(3);
        cmp("rs_pll_reset_3", 32'(pll_reset), 32'd1);
        cyc(1);
        cmp("rs_pll_reset_4", 32'(pll_reset), 32'd0);
        wait_ready("rs_run_timeout", 100);

        // Asynchronous reset in the middle of the release sequence.
        pulse_reset(1'b1);
        cyc(15);
        cmp("ar_rst_pre", 32'(rst_out), 32'b100);
        #1 reset = 1'b1;
        #1;
        cmp("ar_rst_out", 32'(rst_out), 32'b111);
        cmp("ar_pll_reset", 32'(pll_reset), 32'd1);
        cmp("ar_ready", 32'(ready), 32'd0);
        cmp("ar_fault", 32'(fault), 32'd0);
        cmp("ar_retry", 32'(retry_cnt), 32'd0);
        @(negedge clkin);
        reset = 1'b0;

        // Random lock segments with occasional restart and reset.
        seg = 0;
        for (int c = 0; c < 6000; c++) begin
            @(negedge clkin);
            restart = 1'b0;
            if (reset) reset = 1'($urandom_range(0, 1));
            else if ($urandom_range(0, 1499) == 0) reset = 1'b1;
            if (seg == 0) begin
                pll_lock = ($urandom_range(0, 3) != 0);
                seg = pll_lock ? int'($urandom_range(1, 80))
                               : int'($urandom_range(1, 30));
            end
            seg--;
            if ($urandom_range(0, 299) == 0) restart = 1'b1;
        end
        @(negedge clkin);
        reset   = 1'b0;
        restart = 1'b0;
        cyc(3);
        chk_en = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule
